// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter using iterative shift-add-3.
// One result every 18 cycles; BCD holds the last result between DONE pulses.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic [11:0] bcd,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADJ   = 2'd1,
        SHIFT = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [19:0] work_r;
    logic [19:0] work_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_s;
    logic [3:0]  cnt_inc_s;
    logic [11:0] bcd_r;
    logic [11:0] bcd_s;
    logic        busy_r;
    logic        busy_s;
    logic        done_r;
    logic        done_s;

    // Digit correction: values 5..9 become 8..12 so the next shift carries into the next digit.
    function automatic logic [3:0] add3(input logic [3:0] d);
        logic [3:0] r;
        if (d >= 4'd5) begin
            r = d + 4'd3;
        end else begin
            r = d;
        end
        return r;
    endfunction

    assign cnt_inc_s = cnt_r + 4'd1;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_s = state_r;
        work_s  = work_r;
        cnt_s   = cnt_r;
        bcd_s   = bcd_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    work_s  = {12'h000, bin};
                    cnt_s   = 4'd0;
                    state_s = ADJ;
                end else begin
                    state_s = IDLE;
                end
            end
            ADJ: begin
                work_s  = {add3(work_r[19:16]), add3(work_r[15:12]),
                           add3(work_r[11:8]), work_r[7:0]};
                state_s = SHIFT;
            end
            SHIFT: begin
                work_s = {work_r[18:0], 1'b0};
                cnt_s  = cnt_inc_s;
                if (cnt_inc_s == 4'd8) begin
                    state_s = FIN;
                end else begin
                    state_s = ADJ;
                end
            end
            FIN: begin
                bcd_s   = work_r[19:8];
                done_s  = 1'b1;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                work_s  = 20'h00000;
                cnt_s   = 4'd0;
            end
        endcase
        // busy is registered from the next state so it rises right after the accepting edge
        busy_s = (state_s != IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            work_r  <= 20'h00000;
            cnt_r   <= 4'd0;
            bcd_r   <= 12'h000;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            work_r  <= work_s;
            cnt_r   <= cnt_s;
            bcd_r   <= bcd_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign bcd  = bcd_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed cases, exhaustive sweep and
// randomized runs compared against a decimal-arithmetic reference.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic        busy;
    logic        done;

    int          tests;
    int          fails;
    logic [11:0] last_bcd;

    bin2bcd_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits by plain division.
    function automatic logic [11:0] ref_bcd(input int b);
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        h = 4'(b / 100);
        t = 4'((b / 10) % 10);
        o = 4'(b % 10);
        return {h, t, o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present START with operand; returns #1 after the accepting edge (edge 0).
    task automatic launch(input logic [7:0] b);
        start = 1'b1;
        bin   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Walk edges 1..17; optionally disturb inputs before edge inj_edge.
    task automatic wait_result(input int b, input string tag, input int inj_edge,
                               input logic inj_start, input logic [7:0] inj_bin);
        logic [11:0] exp;
        int          rt;
        exp = ref_bcd(b);
        for (int k = 1; k <= 17; k++) begin
            if (k == inj_edge) begin
                start = inj_start;
                bin   = inj_bin;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (k < 17) begin
                chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
                chk({tag, "_done_early"}, {31'd0, done}, 32'd0);
                chk({tag, "_bcd_hold"}, {20'd0, bcd}, {20'd0, last_bcd});
            end else begin
                chk({tag, "_busy_fin"}, {31'd0, busy}, 32'd0);
                chk({tag, "_done"}, {31'd0, done}, 32'd1);
                chk({tag, "_bcd"}, {20'd0, bcd}, {20'd0, exp});
                rt = int'(bcd[11:8]) * 100 + int'(bcd[7:4]) * 10 + int'(bcd[3:0]);
                chk({tag, "_roundtrip"}, rt, b);
                chk({tag, "_digits"}, {31'd0, (bcd[11:8] <= 4'd9) && (bcd[7:4] <= 4'd9)
                                            && (bcd[3:0] <= 4'd9)}, 32'd1);
                last_bcd = exp;
            end
        end
    endtask

    // Idle cycles: no DONE, not busy, result held.
    task automatic check_idle(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            chk({tag, "_idle_done"}, {31'd0, done}, 32'd0);
            chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
            chk({tag, "_idle_bcd"}, {20'd0, bcd}, {20'd0, last_bcd});
        end
    endtask

    initial begin
        int b;
        int ie;
        tests    = 0;
        fails    = 0;
        last_bcd = 12'h000;
        rst      = 1'b1;
        start    = 1'b0;
        bin      = 8'd0;
        #1;
        chk("reset_bcd", {20'd0, bcd}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Zero operand, accepted at first edge after reset release
        launch(8'd0);
        wait_result(0, "bin0", 0, 1'b0, 8'd0);
        check_idle(2, "bin0");

        // Directed values
        launch(8'd255); wait_result(255, "bin255", 0, 1'b0, 8'd0); check_idle(1, "bin255");
        launch(8'd99);  wait_result(99, "bin99", 0, 1'b0, 8'd0);   check_idle(1, "bin99");
        launch(8'd100); wait_result(100, "bin100", 0, 1'b0, 8'd0); check_idle(1, "bin100");
        launch(8'd9);   wait_result(9, "bin9", 0, 1'b0, 8'd0);     check_idle(1, "bin9");

        // START while busy is ignored
        launch(8'd42);
        wait_result(42, "busy_start", 5, 1'b1, 8'd7);
        check_idle(20, "busy_start");

        // Operand change after capture
        launch(8'd63);
        wait_result(63, "bin_change", 1, 1'b0, 8'd64);
        check_idle(1, "bin_change");

        // Reset mid-conversion aborts
        launch(8'd200);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
        end
        #3;
        rst = 1'b1;
        #1;
        last_bcd = 12'h000;
        chk("abort_bcd", {20'd0, bcd}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("abort_hold_done", {31'd0, done}, 32'd0);
            chk("abort_hold_busy", {31'd0, busy}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        launch(8'd13);
        wait_result(13, "after_abort", 0, 1'b0, 8'd0);
        check_idle(1, "after_abort");

        // Exhaustive sweep, START re-issued in each DONE cycle (18-cycle spacing)
        for (int i = 0; i < 256; i++) begin
            launch(8'(i));
            wait_result(i, "sweep", 0, 1'b0, 8'd0);
        end
        check_idle(2, "sweep_end");

        // Randomized operands with random disturbances mid-flight
        for (int i = 0; i < 40; i++) begin
            b  = int'($urandom_range(255, 0));
            ie = int'($urandom_range(16, 1));
            launch(8'(b));
            wait_result(b, "rand", ie, 1'($urandom_range(1, 0)), 8'($urandom_range(255, 0)));
            check_idle(int'($urandom_range(2, 1)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameters: none; data widths fixed at 8-bit binary in, 12-bit (3-digit) BCD out.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 START  input  1  request pulse; sampled only when idle.
REQ-005 BIN  input  8  unsigned binary operand, 0..255; captured on accepted START.
REQ-006 BCD  output  12  result; [11:8] hundreds, [7:4] tens, [3:0] ones, each digit 0..9.
REQ-007 BUSY  output  1  high while a conversion is in progress.
REQ-008 DONE  output  1  single-cycle pulse; BCD holds a new valid result.

Function
REQ-009 Conversion SHALL use iterative shift-add-3 (double dabble): 20-bit working register {digits[11:0], bin[7:0]}, 4-bit iteration counter.
REQ-010 States SHALL be IDLE, ADJ, SHIFT, FIN.
REQ-011 IDLE: START=1 at an edge -> load bin=BIN, digits=0, counter=0, go ADJ; START=0 -> stay IDLE.
REQ-012 ADJ: each working digit >=5 gets +3 (4-bit add, no carry out of digit); digits <5 unchanged; go SHIFT.
REQ-013 SHIFT: working register shifts left 1 (MSB discarded, LSB 0), counter+1; counter reaching 8 -> FIN, else -> ADJ.
REQ-014 FIN: BCD <= working digits, DONE=1 for exactly this one edge-to-edge cycle, go IDLE.
REQ-015 Latency: START sampled at edge 0 -> DONE high and BCD valid after edge 17; 8 ADJ + 8 SHIFT cycles, fixed, operand-independent.
REQ-016 BUSY SHALL be 1 in ADJ, SHIFT, FIN; 0 in IDLE; registered, rises after edge 0.
REQ-017 DONE and BUSY both high in the FIN-exit cycle is forbidden: DONE is asserted in the cycle after FIN (state IDLE, BUSY=0).
REQ-018 START while BUSY=1 SHALL be ignored; no queuing, in-flight operand unaffected.
REQ-019 BIN changes after capture SHALL not affect the running conversion.
REQ-020 START high in the DONE cycle (IDLE) SHALL be accepted; back-to-back throughput one result per 18 cycles.
REQ-021 START held high continuously SHALL restart a new conversion each time IDLE is reached.
REQ-022 BCD SHALL hold its last result between DONE pulses; never shows intermediate working values.
REQ-023 Every output digit SHALL be <=9 for every BIN in 0..255; max result 0x255.

Reset
REQ-024 RST=1 SHALL immediately force state IDLE, BCD=12'h000, BUSY=0, DONE=0, working register and counter =0.
REQ-025 RST asserted mid-conversion SHALL abort it; no DONE pulse for the aborted operand.
REQ-026 First START SHALL be accepted at the first rising edge after RST deasserts.

Verification
REQ-027 RST, then START with BIN=8'd0 -> DONE at edge 17, BCD=12'h000, BUSY high edges 1..17 window only.
REQ-028 BIN=8'd255 -> BCD=12'h255; BIN=8'd99 -> 12'h099; BIN=8'd100 -> 12'h100; BIN=8'd9 -> 12'h009.
REQ-029 Exhaustive sweep BIN 0..255 with START re-issued in each DONE cycle -> every result equals decimal of BIN, spacing 18 cycles, each result matches BCD-to-binary round trip.
REQ-030 START with BIN=8'd42, then START with BIN=8'd7 at edge 5 -> single DONE at edge 17 with BCD=12'h042; no second DONE.
REQ-031 START with BIN=8'd200, RST pulsed at cycle 8 -> outputs 0 asynchronously, no DONE; next START BIN=8'd13 -> BCD=12'h013 after 17 edges.
REQ-032 Change BIN from 8'd63 to 8'd64 one cycle after START accepted -> BCD=12'h063.
